// File: rtl/adc045_block_avg.sv
// Block averager for the ADC045 sample stream. Sums sync-aligned blocks of 2^LOG2_N
// samples and queues {seq, average} in a first-word-fall-through FIFO.
module adc045_block_avg #(
    parameter int DATA_W     = 24,
    parameter int LOG2_N     = 4,
    parameter int FIFO_DEPTH = 8,
    parameter int SEQ_W      = 16
) (
    input  logic                            clk,
    input  logic                            nRST,
    input  logic                            sync,
    input  logic                            ready_sample,
    input  logic [DATA_W-1:0]               adc045_data,
    output logic                            m_valid,
    input  logic                            m_ready,
    output logic [DATA_W-1:0]               m_data,
    output logic [SEQ_W-1:0]                m_seq,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_level,
    output logic                            ovf,
    input  logic                            ovf_clr,
    output logic [7:0]                      abort_cnt
);

    // state      | meaning
    // WAIT_SYNC  | idle after reset, samples ignored until the first sync
    // ACCUM      | summing samples into the current block
    typedef enum logic {ST_WAIT_SYNC, ST_ACCUM} state_t;

    localparam int ACC_W = DATA_W + LOG2_N;
    localparam int CNT_W = LOG2_N;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int ENT_W = SEQ_W + DATA_W;
    localparam int N     = 1 << LOG2_N;

    state_t                  state_q, state_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [SEQ_W-1:0]        seq_q, seq_d;
    logic                    pend_vld_q, pend_vld_d;
    logic [DATA_W-1:0]       pend_data_q, pend_data_d;
    logic [SEQ_W-1:0]        pend_seq_q, pend_seq_d;
    logic [ENT_W-1:0]        mem_q [FIFO_DEPTH];
    logic [ENT_W-1:0]        mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]        level_q, level_d;
    logic                    ovf_q, ovf_d;
    logic [7:0]              abort_q, abort_d;

    logic signed [ACC_W-1:0] data_ext;
    logic signed [ACC_W-1:0] acc_sum;
    logic                    pop;
    logic                    full;
    logic                    push_ok;

    assign data_ext = {{LOG2_N{adc045_data[DATA_W-1]}}, adc045_data};
    assign acc_sum  = acc_q + data_ext;

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        seq_d       = seq_q;
        abort_d     = abort_q;
        pend_vld_d  = 1'b0;
        pend_data_d = pend_data_q;
        pend_seq_d  = pend_seq_q;

        if (sync) begin
            // sync wins over a completing sample; the partial block is dropped
            if (state_q == ST_ACCUM && cnt_q != '0 && abort_q != 8'hFF)
                abort_d = abort_q + 8'd1;
            state_d = ST_ACCUM;
            seq_d   = '0;
            if (ready_sample) begin
                acc_d = data_ext;
                cnt_d = CNT_W'(1);
            end else begin
                acc_d = '0;
                cnt_d = '0;
            end
        end else if (state_q == ST_ACCUM && ready_sample) begin
            if (cnt_q == CNT_W'(N - 1)) begin
                // upper slice of the final sum is the floor-rounded arithmetic shift
                pend_vld_d  = 1'b1;
                pend_data_d = acc_sum[ACC_W-1:LOG2_N];
                pend_seq_d  = seq_q;
                acc_d       = '0;
                cnt_d       = '0;
                seq_d       = seq_q + SEQ_W'(1);
            end else begin
                acc_d = acc_sum;
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    assign pop     = (level_q != '0) && m_ready;
    assign full    = (level_q == LVL_W'(FIFO_DEPTH));
    assign push_ok = pend_vld_q && (!full || pop);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        ovf_d    = ovf_q;

        if (push_ok) begin
            mem_d[wr_ptr_q] = {pend_seq_q, pend_data_q};
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop)
            rd_ptr_d = rd_ptr_q + PTR_W'(1);

        case ({push_ok, pop})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase

        if (ovf_clr)
            ovf_d = 1'b0;
        if (pend_vld_q && !push_ok)
            ovf_d = 1'b1;
    end

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            state_q     <= ST_WAIT_SYNC;
            acc_q       <= '0;
            cnt_q       <= '0;
            seq_q       <= '0;
            pend_vld_q  <= 1'b0;
            pend_data_q <= '0;
            pend_seq_q  <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            ovf_q       <= 1'b0;
            abort_q     <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++)
                mem_q[i] <= '0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            seq_q       <= seq_d;
            pend_vld_q  <= pend_vld_d;
            pend_data_q <= pend_data_d;
            pend_seq_q  <= pend_seq_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            ovf_q       <= ovf_d;
            abort_q     <= abort_d;
            mem_q       <= mem_d;
        end
    end

    assign m_valid         = (level_q != '0);
    assign {m_seq, m_data} = mem_q[rd_ptr_q];
    assign fifo_level      = level_q;
    assign ovf             = ovf_q;
    assign abort_cnt       = abort_q;

endmodule

// File: tb/tb_adc045_block_avg.sv
// Directed bench for adc045_block_avg: table of block vectors plus hand-written
// sequences for pre-sync, abort, overflow/back-pressure and mid-block reset.
module tb_adc045_block_avg;

    logic        clk;
    logic        nRST;
    logic        sync;
    logic        ready_sample;
    logic [23:0] adc045_data;
    logic        m_valid;
    logic        m_ready;
    logic [23:0] m_data;
    logic [15:0] m_seq;
    logic [3:0]  fifo_level;
    logic        ovf;
    logic        ovf_clr;
    logic [7:0]  abort_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    adc045_block_avg dut (
        .clk          (clk),
        .nRST         (nRST),
        .sync         (sync),
        .ready_sample (ready_sample),
        .adc045_data  (adc045_data),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .m_data       (m_data),
        .m_seq        (m_seq),
        .fifo_level   (fifo_level),
        .ovf          (ovf),
        .ovf_clr      (ovf_clr),
        .abort_cnt    (abort_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [23:0] a;
        logic [23:0] b;
        logic [23:0] exp_data;
        logic [15:0] exp_seq;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [39:0] act, input logic [39:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic sample(input logic [23:0] d, input logic s);
        ready_sample = 1'b1;
        adc045_data  = d;
        sync         = s;
        tick(1);
        ready_sample = 1'b0;
        sync         = 1'b0;
    endtask

    task automatic pulse_sync();
        sync = 1'b1;
        tick(1);
        sync = 1'b0;
    endtask

    task automatic block(input logic [23:0] a, input logic [23:0] b);
        for (int i = 0; i < 16; i++)
            sample((i % 2 == 0) ? a : b, 1'b0);
    endtask

    task automatic do_reset();
        nRST = 1'b0;
        tick(2);
        nRST = 1'b1;
        tick(1);
    endtask

    initial begin
        vecs[0] = '{24'h000010, 24'h000010, 24'h000010, 16'd0};
        vecs[1] = '{24'h000010, 24'h000010, 24'h000010, 16'd1};
        vecs[2] = '{24'hFFFFFF, 24'h000000, 24'hFFFFFF, 16'd2};
        vecs[3] = '{24'h7FFFFF, 24'h7FFFFF, 24'h7FFFFF, 16'd3};
        vecs[4] = '{24'h800000, 24'h800000, 24'h800000, 16'd4};
        vecs[5] = '{24'h000005, 24'h000000, 24'h000002, 16'd5};
        vecs[6] = '{24'hFFFFFB, 24'h000000, 24'hFFFFFD, 16'd6};

        nRST = 1'b0; sync = 1'b0; ready_sample = 1'b0; adc045_data = '0;
        m_ready = 1'b0; ovf_clr = 1'b0;
        tick(2);
        chk("rst_m_valid", 40'(m_valid), 40'd0);
        chk("rst_m_data", 40'(m_data), 40'd0);
        chk("rst_m_seq", 40'(m_seq), 40'd0);
        chk("rst_level", 40'(fifo_level), 40'd0);
        chk("rst_ovf", 40'(ovf), 40'd0);
        chk("rst_abort", 40'(abort_cnt), 40'd0);
        nRST = 1'b1;
        tick(1);

        // table: one block per vector, m_ready held high
        m_ready = 1'b1;
        pulse_sync();
        for (int v = 0; v < 7; v++) begin
            block(vecs[v].a, vecs[v].b);
            chk("vec_latency_valid_low", 40'(m_valid), 40'd0);
            tick(1);
            chk("vec_valid", 40'(m_valid), 40'd1);
            chk("vec_data", 40'(m_data), 40'(vecs[v].exp_data));
            chk("vec_seq", 40'(m_seq), 40'(vecs[v].exp_seq));
            chk("vec_level", 40'(fifo_level), 40'd1);
            tick(1);
            chk("vec_popped", 40'(m_valid), 40'd0);
        end

        // samples before any sync are ignored
        do_reset();
        for (int i = 0; i < 20; i++)
            sample(24'h000100, 1'b0);
        tick(2);
        chk("presync_valid", 40'(m_valid), 40'd0);
        chk("presync_level", 40'(fifo_level), 40'd0);
        sample(24'h000100, 1'b1);
        for (int i = 0; i < 15; i++)
            sample(24'h000100, 1'b0);
        tick(1);
        chk("sync_coinc_valid", 40'(m_valid), 40'd1);
        chk("sync_coinc_data", 40'(m_data), 40'h000100);
        chk("sync_coinc_seq", 40'(m_seq), 40'd0);
        tick(1);

        // partial block aborted by sync
        for (int i = 0; i < 5; i++)
            sample(24'h000020, 1'b0);
        pulse_sync();
        tick(3);
        chk("abort_no_output", 40'(m_valid), 40'd0);
        chk("abort_cnt_1", 40'(abort_cnt), 40'd1);
        block(24'h000020, 24'h000020);
        tick(1);
        chk("after_abort_valid", 40'(m_valid), 40'd1);
        chk("after_abort_data", 40'(m_data), 40'h000020);
        chk("after_abort_seq", 40'(m_seq), 40'd0);
        tick(1);
        pulse_sync();
        tick(1);
        chk("abort_cnt_zero_cnt", 40'(abort_cnt), 40'd1);

        // back-pressure: 9 blocks into an 8-deep FIFO
        m_ready = 1'b0;
        for (int k = 0; k < 9; k++)
            block(24'(k + 1), 24'(k + 1));
        tick(2);
        chk("full_level", 40'(fifo_level), 40'd8);
        chk("full_ovf", 40'(ovf), 40'd1);
        chk("full_valid", 40'(m_valid), 40'd1);
        tick(3);
        chk("stall_hold_data", 40'(m_data), 40'd1);
        chk("stall_hold_seq", 40'(m_seq), 40'd0);
        for (int j = 0; j < 8; j++) begin
            m_ready = 1'b0;
            tick(1);
            chk("drain_hold_valid", 40'(m_valid), 40'd1);
            chk("drain_hold_seq", 40'(m_seq), 40'(j));
            m_ready = 1'b1;
            chk("drain_data", 40'(m_data), 40'(j + 1));
            tick(1);
        end
        chk("drained_valid", 40'(m_valid), 40'd0);
        chk("drained_level", 40'(fifo_level), 40'd0);
        block(24'h00000A, 24'h00000A);
        tick(1);
        chk("gap_seq", 40'(m_seq), 40'd9);
        chk("gap_data", 40'(m_data), 40'h00000A);
        tick(1);
        chk("ovf_sticky", 40'(ovf), 40'd1);
        ovf_clr = 1'b1;
        tick(1);
        ovf_clr = 1'b0;
        chk("ovf_cleared", 40'(ovf), 40'd0);

        // asynchronous reset mid-block with 3 entries queued
        m_ready = 1'b0;
        pulse_sync();
        for (int k = 0; k < 3; k++)
            block(24'h000040, 24'h000040);
        for (int i = 0; i < 7; i++)
            sample(24'h000040, 1'b0);
        tick(1);
        chk("pre_rst_level", 40'(fifo_level), 40'd3);
        nRST = 1'b0;
        #1;
        chk("async_rst_valid", 40'(m_valid), 40'd0);
        chk("async_rst_data", 40'(m_data), 40'd0);
        chk("async_rst_seq", 40'(m_seq), 40'd0);
        chk("async_rst_level", 40'(fifo_level), 40'd0);
        chk("async_rst_abort", 40'(abort_cnt), 40'd0);
        #3;
        nRST = 1'b1;
        tick(1);
        m_ready = 1'b1;
        pulse_sync();
        block(24'h000033, 24'h000033);
        tick(1);
        chk("post_rst_valid", 40'(m_valid), 40'd1);
        chk("post_rst_data", 40'(m_data), 40'h000033);
        chk("post_rst_seq", 40'(m_seq), 40'd0);
        tick(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/adc045_block_avg.md
Name: adc045_block_avg

Overview:
- Sits directly downstream of the ADC045 reader wrapper. Consumes its `ready_sample` / `adc045_data` stream of 24-bit two's-complement samples.
- Averages fixed blocks of 2^LOG2_N samples, aligned to the system `sync` pulse.
- Buffers results in a small FWFT FIFO with a valid/ready output, so the packet/host side can absorb back-pressure without losing sample alignment.

Parameters:
- DATA_W, 24, sample width (signed).
- LOG2_N, 4, log2 of samples per block (N=16).
- FIFO_DEPTH, 8, output FIFO entries; power of 2, at least 2.
- SEQ_W, 16, block sequence counter width.

Ports:
- clk  in  1  system clock.
- nRST  in  1  reset, asynchronous, active-low.
- sync  in  1  1-cycle frame-alignment pulse; restarts block accumulation.
- ready_sample  in  1  1-cycle strobe; adc045_data valid this cycle.
- adc045_data  in  DATA_W  signed sample.
- m_valid  out  1  FIFO head valid.
- m_ready  in  1  consumer accepts head when m_valid && m_ready.
- m_data  out  DATA_W  block average (signed).
- m_seq  out  SEQ_W  sequence number of head block.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- ovf  out  1  sticky: a completed block was dropped because the FIFO was full.
- ovf_clr  in  1  clears ovf.
- abort_cnt  out  8  count of partial blocks discarded by sync; saturates at 255.

Behaviour:
- Reset values: state WAIT_SYNC, acc=0, cnt=0, seq=0, FIFO empty, m_valid=0, m_data=0, m_seq=0, fifo_level=0, ovf=0, abort_cnt=0. Reset mid-block discards everything.
- Accumulator width ACC_W = DATA_W+LOG2_N. Samples are sign-extended, so no overflow is possible.
- Average = acc_final >>> LOG2_N: arithmetic shift, floor rounding (toward -inf).
- WAIT_SYNC:
  - ready_sample is ignored.
  - On sync: go to ACCUM. If ready_sample is also high that cycle, acc=sext(data), cnt=1; otherwise acc=0, cnt=0.
- ACCUM, ready_sample without sync:
  - If cnt < N-1: acc += sext(data), cnt++.
  - If cnt == N-1 (block complete): compute avg of (acc+sext(data)); push {seq, avg}; then acc=0, cnt=0, seq++ (wraps max to 0).
- ACCUM, sync (priority over completion):
  - Partial block is discarded. abort_cnt++ if cnt != 0 (saturating).
  - seq is reset to 0.
  - If ready_sample is coincident, that sample becomes the first of the new block (acc=sext(data), cnt=1). Otherwise acc=0, cnt=0.
  - State stays ACCUM.
- seq increments on every completed block, including blocks dropped on overflow, so gaps in m_seq are visible downstream.
- FIFO push:
  - Accepted when level < FIFO_DEPTH, or when level == FIFO_DEPTH and a pop occurs in the same cycle (level unchanged).
  - Otherwise the entry is dropped and ovf is set.
  - Set has priority over a coincident ovf_clr.
- FIFO pop: first-word-fall-through. m_valid = (level != 0). m_data/m_seq reflect the head entry. Pop when m_valid && m_ready.
- Latency:
  - A completing sample at clock edge t, with the FIFO empty, gives m_valid=1 with data after edge t+1 (registered output).
  - Push and pop in the same cycle when level == 1 keep m_valid high, showing the new entry.
- m_valid, m_data and m_seq must be stable while m_valid && !m_ready.
- fifo_level updates: +1 on push, -1 on pop, unchanged on both or neither.

Test Plan:
1. Reset, pulse sync, 16 samples of 0x000010 with m_ready=1 -> one beat m_data=0x000010, m_seq=0, m_valid one cycle after the 16th strobe. A further 16 samples -> m_seq=1.
2. 16 samples alternating 0xFFFFFF and 0x000000 -> sum -8 -> m_data=0xFFFFFF. 16 samples of 0x7FFFFF -> 0x7FFFFF. 16 samples of 0x800000 -> 0x800000.
3. 20 samples before any sync -> no output. Then sync coincident with a sample of 0x000100, followed by 15 samples of 0x000100 -> m_data=0x000100, m_seq=0.
4. After sync, 5 samples then another sync -> no output, abort_cnt=1. 16 further samples -> m_seq=0 output. A sync with cnt=0 -> abort_cnt stays 1.
5. m_ready=0, 9 blocks of 16 -> fifo_level=8, ovf=1. Raising m_ready drains m_seq 0..7 in order, holding values while stalled. A 10th block -> m_seq=9. ovf_clr -> ovf=0.
6. Assert nRST low mid-block (cnt=7, FIFO holding 3 entries) -> all outputs return to reset values immediately. A fresh sync plus 16 samples -> m_seq=0.
